// File: rtl/iob_eth_defs.sv
// iob_eth_defs: shared constants for the minimal Ethernet MAC.
// Holds the bus geometry (address/data width, frame size) and the CPU
// register map. It also holds the line constants (preamble nibble and
// count, SFD nibble) and the TX/RX FSM state encodings.
package iob_eth_defs;

  localparam int ETH_ADDR_W = 12;
  localparam int ETH_DATA_W = 8;
  localparam int ETH_SIZE   = 64;

  // buffer index width and TX nibble counter width (must hold 2*ETH_SIZE)
  localparam int ETH_AW    = $clog2(ETH_SIZE);
  localparam int ETH_NIB_W = $clog2(2 * ETH_SIZE) + 1;

  localparam logic [ETH_ADDR_W-1:0] ETH_STATUS  = ETH_ADDR_W'(12'h000);
  localparam logic [ETH_ADDR_W-1:0] ETH_CONTROL = ETH_ADDR_W'(12'h001);
  localparam logic [ETH_ADDR_W-1:0] ETH_TX_DATA = ETH_ADDR_W'(12'h800);
  localparam logic [ETH_ADDR_W-1:0] ETH_RX_DATA = ETH_ADDR_W'(12'hC00);
  localparam logic [ETH_ADDR_W-1:0] ETH_TX_END  = ETH_TX_DATA + ETH_ADDR_W'(ETH_SIZE);
  localparam logic [ETH_ADDR_W-1:0] ETH_RX_END  = ETH_RX_DATA + ETH_ADDR_W'(ETH_SIZE);

  localparam logic [3:0] ETH_PREAMBLE     = 4'h5;
  localparam int         ETH_PREAMBLE_LEN = 15;
  localparam logic [3:0] ETH_SFD          = 4'hD;

  typedef enum logic [2:0] {
    ST_TX_IDLE,
    ST_TX_PREAMBLE,
    ST_TX_SFD,
    ST_TX_DATA,
    ST_TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    ST_RX_IDLE,
    ST_RX_DATA,
    ST_RX_DONE
  } rx_state_t;

endpackage

// File: rtl/iob_eth_dpram.sv
// iob_eth_dpram: dual-clock simple dual-port RAM, DEPTH x WIDTH.
// Ports:
//   i_wclk  write clock          i_rst   async reset (clears contents)
//   i_we    write enable         i_waddr write address, i_wdata write data
//   i_raddr read address         o_rdata asynchronous read data
// The read is combinational so the consumer's own register captures the
// addressed entry on the same edge that presents the address.
module iob_eth_dpram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     i_wclk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_wclk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/iob_eth_core.sv
// iob_eth_core: minimal Ethernet MAC with a 4-bit MII-style PHY interface
// and single-frame TX/RX buffers. No CRC is sent or checked.
// Ports:
//   clk, rst          system clock, async active-high reset (all domains)
//   sel, we, addr     CPU bus select / write enable / address
//   data_in, data_out CPU write data / registered read data
//   ETH_RESETN        PHY reset, active-low
//   TX_CLK, TX_DATA, TX_EN   PHY transmit clock, nibble, enable
//   RX_CLK, RX_DATA, RX_DV   PHY receive clock, nibble, data valid
//   interrupt         only when ETH_INTERRUPT_EN is defined
// Build option: `define ETH_INTERRUPT_EN adds the interrupt output.
module iob_eth_core
  import iob_eth_defs::*;
(
`ifdef ETH_INTERRUPT_EN
  output logic                  interrupt,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  we,
  input  logic [ETH_ADDR_W-1:0] addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  ETH_RESETN,
  input  logic                  TX_CLK,
  output logic [3:0]            TX_DATA,
  output logic                  TX_EN,
  input  logic                  RX_CLK,
  input  logic [3:0]            RX_DATA,
  input  logic                  RX_DV
);

  // ---------------- clk domain: bus interface ----------------
  logic       r_tx_ready, r_rx_ready;
  logic       r_tx_req_tgl, r_rx_ack_tgl;
  logic [2:0] r_txd_sync, r_rxd_sync;
  logic       r_tx_done_tgl, r_rx_done_tgl;

  logic w_wr, w_rd, w_ctrl_wr, w_start, w_ack;
  logic w_tx_hit, w_rx_hit, w_txbuf_we;
  logic w_tx_done_evt, w_rx_done_evt;
  logic [ETH_DATA_W-1:0] w_txbuf_rdata, w_rxbuf_rdata;
  logic [31:0] w_rd_data;
  logic w_unused_bits;

  assign w_wr      = sel & we;
  assign w_rd      = sel & ~we;
  assign w_ctrl_wr = w_wr && (addr == ETH_CONTROL);
  assign w_start   = w_ctrl_wr && data_in[0] && r_tx_ready;
  // ack only toggles while a frame is held, so the receiver sees it in DONE
  assign w_ack     = w_ctrl_wr && data_in[1] && r_rx_ready;
  assign w_tx_hit  = (addr >= ETH_TX_DATA) && (addr < ETH_TX_END);
  assign w_rx_hit  = (addr >= ETH_RX_DATA) && (addr < ETH_RX_END);
  assign w_txbuf_we = w_wr && w_tx_hit && r_tx_ready;
  assign w_tx_done_evt = r_txd_sync[1] ^ r_txd_sync[2];
  assign w_rx_done_evt = r_rxd_sync[1] ^ r_rxd_sync[2];
  assign w_unused_bits = ^data_in[31:ETH_DATA_W];

  always_comb begin
    w_rd_data = '0;
    if (addr == ETH_STATUS)
      w_rd_data = 32'({r_rx_ready, r_tx_ready});
    else if (w_rx_hit)
      w_rd_data = 32'(w_rxbuf_rdata);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ETH_RESETN   <= 1'b0;
      r_tx_ready   <= 1'b1;
      r_rx_ready   <= 1'b0;
      r_tx_req_tgl <= 1'b0;
      r_rx_ack_tgl <= 1'b0;
      r_txd_sync   <= '0;
      r_rxd_sync   <= '0;
      data_out     <= '0;
    end else begin
      ETH_RESETN <= 1'b1;
      r_txd_sync <= {r_txd_sync[1:0], r_tx_done_tgl};
      r_rxd_sync <= {r_rxd_sync[1:0], r_rx_done_tgl};
      if (w_start) begin
        r_tx_ready   <= 1'b0;
        r_tx_req_tgl <= ~r_tx_req_tgl;
      end else if (w_tx_done_evt) begin
        r_tx_ready <= 1'b1;
      end
      if (w_rx_done_evt) begin
        r_rx_ready <= 1'b1;
      end else if (w_ack) begin
        r_rx_ready   <= 1'b0;
        r_rx_ack_tgl <= ~r_rx_ack_tgl;
      end
      if (w_rd) data_out <= w_rd_data;
    end
  end

`ifdef ETH_INTERRUPT_EN
  logic r_tx_done_flag, r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_done_flag <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      if (w_tx_done_evt)  r_tx_done_flag <= 1'b1;
      else if (w_ctrl_wr) r_tx_done_flag <= 1'b0;
      r_irq <= r_rx_ready | r_tx_done_flag;
    end
  end

  assign interrupt = r_irq;
`endif

  // ---------------- TX_CLK domain ----------------
  tx_state_t r_tx_state, w_tx_state_nxt;
  logic [ETH_NIB_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [3:0] w_txd_nxt, w_nib;
  logic       w_txen_nxt, w_tx_done_tgl_nxt;
  logic [1:0] r_req_sync;
  logic       r_req_seen, w_req_seen_nxt;

  // r_tx_cnt is the index of the next payload nibble: byte = cnt>>1,
  // odd index selects the high nibble
  assign w_nib = r_tx_cnt[0] ? w_txbuf_rdata[7:4] : w_txbuf_rdata[3:0];

  always_comb begin
    w_tx_state_nxt    = r_tx_state;
    w_tx_cnt_nxt      = r_tx_cnt;
    w_txd_nxt         = TX_DATA;
    w_txen_nxt        = TX_EN;
    w_tx_done_tgl_nxt = r_tx_done_tgl;
    w_req_seen_nxt    = r_req_seen;
    case (r_tx_state)
      ST_TX_IDLE: begin
        w_txd_nxt  = '0;
        w_txen_nxt = 1'b0;
        if (r_req_sync[1] != r_req_seen) begin
          w_req_seen_nxt = r_req_sync[1];
          w_tx_state_nxt = ST_TX_PREAMBLE;
          w_txd_nxt      = ETH_PREAMBLE;
          w_txen_nxt     = 1'b1;
          w_tx_cnt_nxt   = ETH_NIB_W'(1);
        end
      end
      ST_TX_PREAMBLE: begin
        if (r_tx_cnt == ETH_NIB_W'(ETH_PREAMBLE_LEN)) begin
          w_tx_state_nxt = ST_TX_SFD;
          w_txd_nxt      = ETH_SFD;
          w_tx_cnt_nxt   = '0;
        end else begin
          w_txd_nxt    = ETH_PREAMBLE;
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      ST_TX_SFD: begin
        w_tx_state_nxt = ST_TX_DATA;
        w_txd_nxt      = w_nib;
        w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
      end
      ST_TX_DATA: begin
        if (r_tx_cnt == ETH_NIB_W'(2 * ETH_SIZE)) begin
          w_tx_state_nxt    = ST_TX_DONE;
          w_txd_nxt         = '0;
          w_txen_nxt        = 1'b0;
          w_tx_done_tgl_nxt = ~r_tx_done_tgl;
        end else begin
          w_txd_nxt    = w_nib;
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      ST_TX_DONE: w_tx_state_nxt = ST_TX_IDLE;
      default:    w_tx_state_nxt = ST_TX_IDLE;
    endcase
  end

  always_ff @(posedge TX_CLK or posedge rst) begin
    if (rst) begin
      r_tx_state    <= ST_TX_IDLE;
      r_tx_cnt      <= '0;
      TX_DATA       <= '0;
      TX_EN         <= 1'b0;
      r_tx_done_tgl <= 1'b0;
      r_req_sync    <= '0;
      r_req_seen    <= 1'b0;
    end else begin
      r_req_sync    <= {r_req_sync[0], r_tx_req_tgl};
      r_tx_state    <= w_tx_state_nxt;
      r_tx_cnt      <= w_tx_cnt_nxt;
      TX_DATA       <= w_txd_nxt;
      TX_EN         <= w_txen_nxt;
      r_tx_done_tgl <= w_tx_done_tgl_nxt;
      r_req_seen    <= w_req_seen_nxt;
    end
  end

  // ---------------- RX_CLK domain ----------------
  rx_state_t r_rx_state, w_rx_state_nxt;
  logic [ETH_AW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic       r_rx_half, w_rx_half_nxt;
  logic [3:0] r_rx_lo, w_rx_lo_nxt;
  logic       w_rx_done_tgl_nxt;
  logic [1:0] r_ack_sync;
  logic       r_ack_seen, w_ack_seen_nxt;
  logic       w_rxbuf_we;
  logic [ETH_DATA_W-1:0] w_rxbuf_wdata;

  assign w_rxbuf_wdata = {RX_DATA, r_rx_lo};

  always_comb begin
    w_rx_state_nxt    = r_rx_state;
    w_rx_cnt_nxt      = r_rx_cnt;
    w_rx_half_nxt     = r_rx_half;
    w_rx_lo_nxt       = r_rx_lo;
    w_rx_done_tgl_nxt = r_rx_done_tgl;
    w_ack_seen_nxt    = r_ack_seen;
    w_rxbuf_we        = 1'b0;
    case (r_rx_state)
      ST_RX_IDLE: begin
        if (RX_DV && RX_DATA == ETH_SFD) begin
          w_rx_state_nxt = ST_RX_DATA;
          w_rx_cnt_nxt   = '0;
          w_rx_half_nxt  = 1'b0;
        end
      end
      ST_RX_DATA: begin
        if (!RX_DV) begin
          w_rx_state_nxt = ST_RX_IDLE;
        end else if (!r_rx_half) begin
          w_rx_lo_nxt   = RX_DATA;
          w_rx_half_nxt = 1'b1;
        end else begin
          w_rxbuf_we    = 1'b1;
          w_rx_half_nxt = 1'b0;
          if (r_rx_cnt == ETH_AW'(ETH_SIZE - 1)) begin
            w_rx_state_nxt    = ST_RX_DONE;
            w_rx_done_tgl_nxt = ~r_rx_done_tgl;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + 1'b1;
          end
        end
      end
      ST_RX_DONE: begin
        if (r_ack_sync[1] != r_ack_seen) begin
          w_ack_seen_nxt = r_ack_sync[1];
          w_rx_state_nxt = ST_RX_IDLE;
        end
      end
      default: w_rx_state_nxt = ST_RX_IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      r_rx_state    <= ST_RX_IDLE;
      r_rx_cnt      <= '0;
      r_rx_half     <= 1'b0;
      r_rx_lo       <= '0;
      r_rx_done_tgl <= 1'b0;
      r_ack_sync    <= '0;
      r_ack_seen    <= 1'b0;
    end else begin
      r_ack_sync    <= {r_ack_sync[0], r_rx_ack_tgl};
      r_rx_state    <= w_rx_state_nxt;
      r_rx_cnt      <= w_rx_cnt_nxt;
      r_rx_half     <= w_rx_half_nxt;
      r_rx_lo       <= w_rx_lo_nxt;
      r_rx_done_tgl <= w_rx_done_tgl_nxt;
      r_ack_seen    <= w_ack_seen_nxt;
    end
  end

  // ---------------- buffers ----------------
  iob_eth_dpram #(.DEPTH(ETH_SIZE), .WIDTH(ETH_DATA_W)) u_tx_buf (
    .i_wclk  (clk),
    .i_rst   (rst),
    .i_we    (w_txbuf_we),
    .i_waddr (addr[ETH_AW-1:0]),
    .i_wdata (data_in[ETH_DATA_W-1:0]),
    .i_raddr (r_tx_cnt[ETH_AW:1]),
    .o_rdata (w_txbuf_rdata)
  );

  iob_eth_dpram #(.DEPTH(ETH_SIZE), .WIDTH(ETH_DATA_W)) u_rx_buf (
    .i_wclk  (RX_CLK),
    .i_rst   (rst),
    .i_we    (w_rxbuf_we),
    .i_waddr (r_rx_cnt),
    .i_wdata (w_rxbuf_wdata),
    .i_raddr (addr[ETH_AW-1:0]),
    .o_rdata (w_rxbuf_rdata)
  );

endmodule

// File: tb/tb_iob_eth_core.sv
// Testbench for iob_eth_core: loopback PHY model, TX nibble scoreboard and
// RX buffer scoreboard, plus a manual RX driver for abort/recovery frames.
module tb_iob_eth_core;

  logic        clk, tclk, rst, sel, we;
  logic [11:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ETH_RESETN;
  logic [3:0]  TX_DATA;
  logic        TX_EN;
  logic [3:0]  RX_DATA;
  logic        RX_DV;

  iob_eth_core dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .we         (we),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .ETH_RESETN (ETH_RESETN),
    .TX_CLK     (tclk),
    .TX_DATA    (TX_DATA),
    .TX_EN      (TX_EN),
    .RX_CLK     (tclk),
    .RX_DATA    (RX_DATA),
    .RX_DV      (RX_DV)
  );

  localparam int LB_DLY = 15;
  localparam logic [11:0] A_STATUS = 12'h000;
  localparam logic [11:0] A_CTRL   = 12'h001;
  localparam logic [11:0] A_TX     = 12'h800;
  localparam logic [11:0] A_RX     = 12'hC00;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_nib[$];
  logic [7:0] q_rx[$];
  int         frame_len[$];
  int         n_frames = 0;
  int         n_extra  = 0;
  int         run      = 0;
  logic [7:0] tx_model[64];

  logic       rx_manual = 1'b0;
  logic       m_dv      = 1'b0;
  logic [3:0] m_data    = '0;
  logic [3:0] dly_d [LB_DLY];
  logic       dly_en[LB_DLY];

  initial begin clk = 0;  forever #5  clk  = ~clk;  end
  initial begin tclk = 0; forever #20 tclk = ~tclk; end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // loopback PHY: RX follows TX delayed by LB_DLY TX_CLK periods
  initial begin
    for (int i = 0; i < LB_DLY; i++) begin dly_d[i] = '0; dly_en[i] = 1'b0; end
    RX_DV = 1'b0; RX_DATA = '0;
    forever begin
      @(negedge tclk);
      for (int i = LB_DLY - 1; i > 0; i--) begin
        dly_d[i]  = dly_d[i-1];
        dly_en[i] = dly_en[i-1];
      end
      dly_d[0]  = TX_DATA;
      dly_en[0] = TX_EN;
      if (rx_manual) begin RX_DV = m_dv; RX_DATA = m_data; end
      else begin RX_DV = dly_en[LB_DLY-1]; RX_DATA = dly_d[LB_DLY-1]; end
    end
  end

  // TX monitor: pops expected nibbles while TX_EN is high, records run lengths
  initial begin
    forever begin
      @(negedge tclk);
      if (TX_EN) begin
        run++;
        if (exp_nib.size() == 0) n_extra++;
        else check("tx_nibble", 32'(TX_DATA), 32'(exp_nib.pop_front()));
      end else if (run != 0) begin
        frame_len.push_back(run);
        n_frames++;
        check("tx_idle_data", 32'(TX_DATA), 32'h0);
        run = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); sel = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk); sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk); sel = 1'b1; we = 1'b0; addr = a;
    @(negedge clk); sel = 1'b0; d = data_out;
  endtask

  task automatic read_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_status(input logic [31:0] mask, input string tag);
    logic [31:0] d;
    int n = 0;
    do begin bus_read(A_STATUS, d); n++; end while (((d & mask) == 0) && n < 3000);
    check(tag, d & mask, mask);
  endtask

  task automatic load_tx();
    for (int i = 0; i < 64; i++) bus_write(A_TX + 12'(i), 32'(tx_model[i]));
  endtask

  task automatic push_tx_frame();
    for (int i = 0; i < 15; i++) exp_nib.push_back(4'h5);
    exp_nib.push_back(4'hD);
    for (int i = 0; i < 64; i++) begin
      exp_nib.push_back(tx_model[i][3:0]);
      exp_nib.push_back(tx_model[i][7:4]);
    end
  endtask

  task automatic push_rx_model();
    for (int i = 0; i < 64; i++) q_rx.push_back(tx_model[i]);
  endtask

  task automatic check_rx_buf(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 64; i++) begin
      bus_read(A_RX + 12'(i), d);
      if (q_rx.size() == 0) check({tag, "_underflow"}, d, 32'hFFFF_FFFF);
      else check(tag, d, 32'(q_rx.pop_front()));
    end
  endtask

  task automatic end_frame_checks(input int frames);
    repeat (40) @(posedge tclk);
    check("tx_frames", 32'(n_frames), 32'(frames));
    if (frame_len.size() > 0) check("tx_en_len", 32'(frame_len.pop_front()), 32'd144);
    check("tx_nibbles_left", 32'(exp_nib.size()), 32'd0);
    check("tx_extra_nibbles", 32'(n_extra), 32'd0);
  endtask

  task automatic drive_nib(input logic dv, input logic [3:0] d);
    @(posedge tclk); #1; m_dv = dv; m_data = d;
  endtask

  task automatic rx_send(input int nbytes, input logic [7:0] base);
    logic [7:0] b;
    for (int i = 0; i < 7; i++) drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = base + 8'(i);
      drive_nib(1'b1, b[3:0]);
      drive_nib(1'b1, b[7:4]);
    end
    drive_nib(1'b0, 4'h0);
  endtask

  initial begin
    sel = 0; we = 0; addr = '0; data_in = '0; rst = 0;
    #1 rst = 1;
    repeat (5) @(negedge clk);
    check("resetn_in_reset", 32'(ETH_RESETN), 32'h0);
    rst = 0;
    check("dout_reset", data_out, 32'h0);
    repeat (2) @(negedge clk);
    check("resetn_after", 32'(ETH_RESETN), 32'h1);
    check("tx_en_reset", 32'(TX_EN), 32'h0);
    check("tx_data_reset", 32'(TX_DATA), 32'h0);
    read_chk("status_reset", A_STATUS, 32'h1);
    read_chk("rx0_reset", A_RX, 32'h0);
    read_chk("ctrl_reads_0", A_CTRL, 32'h0);

    // Frame A: loopback payload i+1, busy behaviour
    for (int i = 0; i < 64; i++) tx_model[i] = 8'(i + 1);
    load_tx();
    push_tx_frame();
    push_rx_model();
    bus_write(A_CTRL, 32'h1);
    read_chk("status_busy", A_STATUS, 32'h0);
    bus_write(A_TX, 32'h77);
    bus_write(A_CTRL, 32'h1);
    read_chk("status_busy2", A_STATUS, 32'h0);
    wait_status(32'h1, "tx_ready_A");
    wait_status(32'h2, "rx_ready_A");
    end_frame_checks(1);
    check_rx_buf("rx_A");

    // Frame B: sent while rx_ready=1, must be dropped; entry 0 keeps 0x01
    for (int i = 1; i < 64; i++) begin
      tx_model[i] = 8'hFF;
      bus_write(A_TX + 12'(i), 32'hFF);
    end
    push_tx_frame();
    bus_write(A_CTRL, 32'h1);
    wait_status(32'h1, "tx_ready_B");
    end_frame_checks(2);
    read_chk("status_hold", A_STATUS, 32'h3);
    for (int i = 0; i < 64; i++) q_rx.push_back(8'(i + 1));
    check_rx_buf("rx_hold");

    // acknowledge, then Frame C with 0xA5 at entry 0
    bus_write(A_CTRL, 32'h2);
    read_chk("status_ack", A_STATUS, 32'h1);
    tx_model[0] = 8'hA5;
    for (int i = 1; i < 64; i++) tx_model[i] = 8'(i * 7 + 3);
    load_tx();
    push_tx_frame();
    push_rx_model();
    bus_write(A_CTRL, 32'h1);
    wait_status(32'h2, "rx_ready_C");
    wait_status(32'h1, "tx_ready_C");
    end_frame_checks(3);
    check_rx_buf("rx_C");

    // Frame D: start and acknowledge in one CONTROL write
    for (int i = 0; i < 64; i++) tx_model[i] = ~8'(i);
    load_tx();
    push_tx_frame();
    push_rx_model();
    bus_write(A_CTRL, 32'h3);
    read_chk("status_start_ack", A_STATUS, 32'h0);
    wait_status(32'h2, "rx_ready_D");
    wait_status(32'h1, "tx_ready_D");
    end_frame_checks(4);
    check_rx_buf("rx_D");

    // abort after 10 bytes, then a full manual frame
    bus_write(A_CTRL, 32'h2);
    read_chk("status_ack2", A_STATUS, 32'h1);
    repeat (5) @(posedge tclk);
    rx_manual = 1'b1;
    rx_send(10, 8'h40);
    repeat (10) @(posedge tclk);
    read_chk("status_abort", A_STATUS, 32'h1);
    for (int i = 0; i < 64; i++) q_rx.push_back(8'h80 + 8'(i));
    rx_send(64, 8'h80);
    wait_status(32'h2, "rx_ready_after_abort");
    check_rx_buf("rx_after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
